instr_encoder: RTL and testbench

//  Inverse of the immediate decoder. Packs instruction fields and a 32-bit immediate

---
 rtl/rv_isa_pkg.sv | 46 ++++
 rtl/instr_pack.sv | 56 +++++
 rtl/instr_encoder.sv | 106 ++++++++++
 tb/tb_instr_encoder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and immediate decoder.
// Also holds the request bundle and the sign-extension range helper.
package rv_isa_pkg;

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_SHAMT = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    // True when imm equals the sign-extension of imm[msb:0].
    function automatic logic fits_signed(input logic [31:0] imm, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > msb && imm[i] != imm[msb]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I word packer: request fields plus immediate in, encoded word and
// range/illegal error out. Errored requests yield the canonical NOP.
import rv_isa_pkg::*;

module instr_pack (
    input  enc_req_t    i_req,
    output logic [31:0] o_word,
    output logic        o_err
);

    logic [31:0] w_raw;
    logic [31:0] w_imm;

    assign w_imm = i_req.imm;

    always_comb begin
        w_raw = NOP_INSTR;
        o_err = 1'b1;
        case (i_req.fmt)
            FMT_I: begin
                w_raw = {w_imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
                o_err = !fits_signed(w_imm, 11);
            end
            FMT_SHAMT: begin
                w_raw = {i_req.funct7, w_imm[4:0], i_req.rs1, i_req.funct3, i_req.rd,
                         i_req.opcode};
                o_err = |w_imm[31:5];
            end
            FMT_S: begin
                w_raw = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3, w_imm[4:0],
                         i_req.opcode};
                o_err = !fits_signed(w_imm, 11);
            end
            FMT_B: begin
                w_raw = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                         w_imm[4:1], w_imm[11], i_req.opcode};
                o_err = !fits_signed(w_imm, 12) || w_imm[0];
            end
            FMT_U: begin
                w_raw = {w_imm[31:12], i_req.rd, i_req.opcode};
                o_err = |w_imm[11:0];
            end
            FMT_J: begin
                w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_req.rd,
                         i_req.opcode};
                o_err = !fits_signed(w_imm, 20) || w_imm[0];
            end
            default: begin
                w_raw = NOP_INSTR;
                o_err = 1'b1;
            end
        endcase
        o_word = o_err ? NOP_INSTR : w_raw;
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: stage A captures the request, stage B
// holds the packed word with its load address and error flag.
import rv_isa_pkg::*;

module instr_encoder #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        ERR_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] addr,
    output logic              range_err,
    output logic [ERR_W-1:0]  err_count
);

    enc_req_t          w_req;
    enc_req_t          r_a_req;
    logic              r_a_vld;
    logic              r_b_vld;
    logic [31:0]       r_instr;
    logic              r_range_err;
    logic [ADDR_W-1:0] r_addr;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_b_free;
    logic              w_accept;
    logic              w_advance;
    logic              w_retire;
    logic [31:0]       w_word;
    logic              w_err;

    assign w_req = '{fmt: fmt, opcode: opcode, funct3: funct3, funct7: funct7,
                     rd: rd, rs1: rs1, rs2: rs2, imm: imm};

    // Stage B can take a word if empty or if its current word leaves this cycle.
    assign w_b_free  = !r_b_vld || out_ready;
    assign in_ready  = !r_a_vld || w_b_free;
    assign w_accept  = in_valid && in_ready;
    assign w_advance = r_a_vld && w_b_free;
    assign w_retire  = r_b_vld && out_ready;

    instr_pack u_pack (
        .i_req  (r_a_req),
        .o_word (w_word),
        .o_err  (w_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a_vld <= 1'b0;
            r_a_req <= '0;
        end else if (w_accept) begin
            r_a_vld <= 1'b1;
            r_a_req <= w_req;
        end else if (w_advance) begin
            r_a_vld <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_b_vld     <= 1'b0;
            r_instr     <= '0;
            r_range_err <= 1'b0;
        end else if (w_advance) begin
            r_b_vld     <= 1'b1;
            r_instr     <= w_word;
            r_range_err <= w_err;
        end else if (w_retire) begin
            r_b_vld <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr    <= BASE_ADDR;
            r_err_cnt <= '0;
        end else if (w_retire) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_range_err && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign out_valid = r_b_vld;
    assign instr     = r_instr;
    assign addr      = r_addr;
    assign range_err = r_range_err;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors, stall/reset scenarios and a long
// randomized round trip checked by decoding emitted words back to fields and immediates.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int unsigned ERR_W  = 2;
    localparam int          ERR_MAX = 3;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd, rs1, rs2;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              range_err;
    logic [ERR_W-1:0]  err_count;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERR_W(ERR_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .addr(addr), .range_err(range_err), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        bit          err;
        bit          has_word;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: stalled, 2: random

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Error rules expressed as numeric ranges on the signed immediate.
    function automatic bit model_err(input logic [2:0] f, input logic [31:0] v_imm);
        longint v;
        bit     odd;
        v   = longint'($signed(v_imm));
        odd = (v_imm % 2) != 0;
        case (f)
            3'd0, 3'd2: return v < -2048 || v > 2047;
            3'd1:       return v_imm > 31;
            3'd3:       return v < -4096 || v > 4095 || odd;
            3'd4:       return (v_imm % 4096) != 0;
            3'd5:       return v < -1048576 || v > 1048575 || odd;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] dec_imm(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd0:    return {{20{w[31]}}, w[31:20]};
            3'd1:    return {27'b0, w[24:20]};
            3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    return {w[31:12], 12'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] fields_of(input logic [2:0] f, input logic [6:0] op,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [4:0] v_rd, input logic [4:0] v_rs1,
                                              input logic [4:0] v_rs2);
        bit u_rd, u_rs1, u_rs2;
        u_rd  = f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5;
        u_rs1 = f <= 3'd3;
        u_rs2 = f == 3'd2 || f == 3'd3;
        return {op, u_rd ? v_rd : 5'b0, u_rs1 ? v_rs1 : 5'b0, u_rs2 ? v_rs2 : 5'b0,
                u_rs1 ? f3 : 3'b0, f == 3'd1 ? f7 : 7'b0};
    endfunction

    function automatic exp_t mk(input logic [2:0] f, input logic [6:0] op,
                                input logic [2:0] f3, input logic [4:0] v_rd,
                                input logic [4:0] v_rs1, input logic [4:0] v_rs2,
                                input logic [31:0] v_imm);
        exp_t e;
        e.fmt = f; e.op = op; e.f3 = f3; e.f7 = 7'h00;
        e.rd = v_rd; e.rs1 = v_rs1; e.rs2 = v_rs2; e.imm = v_imm;
        e.err = model_err(f, v_imm);
        e.has_word = e.err;
        e.word = NOP;
        return e;
    endfunction

    function automatic exp_t rand_req(input bit in_range);
        exp_t        e;
        logic [31:0] v;
        logic [2:0]  f;
        f = in_range ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
        case (f)
            3'd0, 3'd2: v = 32'($urandom_range(0, 4095)) - 32'd2048;
            3'd1:       v = 32'($urandom_range(0, 31));
            3'd3:       v = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            3'd4:       v = $urandom & 32'hFFFF_F000;
            default:    v = (32'($urandom_range(0, 32'hF_FFFF)) - 32'h8_0000) << 1;
        endcase
        if (!in_range && $urandom_range(0, 1) == 1) v = $urandom;
        e = mk(f, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), v);
        e.f7 = 7'($urandom);
        return e;
    endfunction

    task automatic align();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input exp_t e);
        in_valid = 1'b1;
        fmt = e.fmt; opcode = e.op; funct3 = e.f3; funct7 = e.f7;
        rd = e.rd; rs1 = e.rs1; rs2 = e.rs2; imm = e.imm;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input exp_t e);
        int t;
        drive(e);
        t = 0;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                chk("accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clock);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        rdy_mode = 0;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clock);
            t++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        align();
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops on every output handshake and checks stall stability.
    int          n_ret = 0;
    int          err_model = 0;
    bit          held = 0;
    logic [31:0] h_instr, h_addr;
    logic        h_err;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb.delete();
                n_ret = 0; err_model = 0; held = 0;
            end else begin
                if (held && out_valid) begin
                    chk("hold_instr", instr, h_instr);
                    chk("hold_addr", addr, h_addr);
                    chk("hold_err", range_err, h_err);
                end
                held = out_valid && !out_ready;
                h_instr = instr; h_addr = addr; h_err = range_err;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_word", instr, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("addr", addr, BASE + 32'(n_ret * 4));
                        chk("range_err", range_err, e.err);
                        chk("err_count", err_count, err_model);
                        if (e.has_word) begin
                            chk("word", instr, e.word);
                        end else begin
                            chk("rt_imm", dec_imm(e.fmt, instr), e.imm);
                            chk("rt_fields",
                                fields_of(e.fmt, instr[6:0], instr[14:12], instr[31:25],
                                          instr[11:7], instr[19:15], instr[24:20]),
                                fields_of(e.fmt, e.op, e.f3, e.f7, e.rd, e.rs1, e.rs2));
                        end
                        n_ret++;
                        if (e.err && err_model < ERR_MAX) err_model++;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1'b1; in_valid = 1'b0;
        fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
        rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_range_err", range_err, 1'b0);
        chk("rst_err_count", err_count, 0);
        chk("rst_addr", addr, BASE);
        chk("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        align();

        // Directed encodings and two-clock latency
        e = mk(3'd0, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        e.has_word = 1; e.word = 32'hFFF0_0093;
        send(e);
        @(negedge clock);
        chk("latency_a", out_valid, 1'b0);
        @(negedge clock);
        chk("latency_b", out_valid, 1'b1);
        align();
        e = mk(3'd3, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        e.has_word = 1; e.word = 32'hFE20_8EE3;
        send(e);
        e = mk(3'd5, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        e.has_word = 1; e.word = 32'h0010_00EF;
        send(e);
        e = mk(3'd4, 7'b0110111, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        e.has_word = 1; e.word = 32'h1234_52B7;
        send(e);
        drain();

        // Out-of-range and illegal requests become NOPs; counter saturates at 3
        send(mk(3'd0, 7'b0010011, 3'd0, 5'd1, 5'd2, 5'd0, 32'd2048));
        send(mk(3'd3, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'd5));
        drain();
        chk("err_count_2", err_count, 2);
        send(mk(3'd7, 7'b0010011, 3'd0, 5'd1, 5'd2, 5'd0, 32'd0));
        drain();
        chk("err_count_3", err_count, 3);
        send(mk(3'd1, 7'b0010011, 3'd1, 5'd1, 5'd2, 5'd0, 32'd32));
        send(mk(3'd4, 7'b0110111, 3'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5001));
        send(mk(3'd5, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000));
        send(mk(3'd6, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0));
        drain();
        chk("err_count_sat", err_count, 3);

        // Reset with both stages full
        rdy_mode = 1;
        align();
        send(rand_req(1));
        send(rand_req(1));
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_addr", addr, BASE);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_in_ready", in_ready, 1'b1);
        align();
        reset = 1'b0;
        rdy_mode = 0;
        align();
        send(rand_req(1));
        drain();

        // Stall: two accepted, third refused until release
        rdy_mode = 1;
        align();
        send(rand_req(1));
        send(rand_req(1));
        e = rand_req(1);
        drive(e);
        repeat (3) @(negedge clock);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        rdy_mode = 0;
        send(e);
        drain();

        // Randomised round trip with random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) send(rand_req(1));
        for (int i = 0; i < 400; i++) send(rand_req(0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
